// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, defaults and prefetch queue entry type for instruction fetch
package fetch_pkg;
  localparam int PC_WIDTH = 16;
  localparam int INSTR_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_STEP = 16'd2;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;
  localparam logic [4:0] DEFAULT_HALT_OPCODE = 5'b11111;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous prefetch FIFO of {pc, instr} entries with flush
// Ports: clk, reset (async, active-high); enq/din write, deq advances head,
// flush empties the queue and overrides enq/deq; full, empty, head (zero when empty).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enq,
  input  logic   deq,
  input  logic   flush,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  entry_t mem [DEPTH];
  logic do_enq, do_deq;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_deq = deq && !empty;
  // a full queue still accepts a write when its head leaves in the same cycle
  assign do_enq = enq && (!full || do_deq);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_enq} - {{AW{1'b0}}, do_deq};
    end
  always_ff @(posedge clk)
    if (do_enq && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, reads the instruction ROM and feeds decode through a prefetch queue
// Ports: clk, reset (async, active-high); imem_pc/imem_instruction to the ROM;
// if_valid/if_instruction/if_pc with id_ready to decode; redirect_valid/redirect_pc
// from branch resolution; halted and a saturating fetch_count for status.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int QUEUE_DEPTH = 2,
  parameter logic [4:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instruction,
  output logic        if_valid,
  output logic [15:0] if_instruction,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;
  logic [0:0] state;
  logic [15:0] pc;
  logic full, empty, enq, deq;
  entry_t head;
  assign imem_pc = pc;
  assign if_valid = !empty;
  assign {if_pc, if_instruction} = head;
  assign halted = state == HALTED;
  assign deq = if_valid && id_ready;
  // a redirect discards whatever would have been captured this cycle
  assign enq = state == FETCH && (!full || deq) && !redirect_valid;
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .reset(reset),
    .enq(enq),
    .deq(deq),
    .flush(redirect_valid),
    .din('{pc: pc, instr: imem_instruction}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      state <= FETCH;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~16'h0001;
      state <= FETCH;
    end else if (enq) begin
      pc <= pc + PC_STEP;
      fetch_count <= fetch_count + {15'd0, fetch_count != 16'hFFFF};
      if (imem_instruction[15:11] == HALT_OPCODE) state <= HALTED;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the program counter, drives the PC to the combinational instruction ROM, and captures each returned 16-bit instruction into a small prefetch queue. It hands instructions to decode over a valid/ready handshake, accepts PC redirects from branch/jump resolution, and stops fetching on a halt opcode. It sits between instruction_memory and the decode stage.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
QUEUE_DEPTH, 2, prefetch queue entries (power of two, >=2)
HALT_OPCODE, 5'b11111, instruction[15:11] value that stops fetching

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_pc  output  16  byte address to instruction memory (bit 0 always 0)
imem_instruction  input  16  combinational ROM data for imem_pc, same cycle
if_valid  output  1  queue head holds a valid instruction
if_instruction  output  16  instruction at queue head
if_pc  output  16  byte address of if_instruction
id_ready  input  1  decode accepts head when high with if_valid
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  16  new fetch address (bit 0 ignored, forced 0)
halted  output  1  fetch stopped on HALT_OPCODE
fetch_count  output  16  instructions enqueued since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high): pc=RESET_PC, queue empty, if_valid=0, if_instruction=0, if_pc=0, halted=0, fetch_count=0. imem_pc=RESET_PC while reset is held. Reset mid-operation discards all queued entries immediately.
- States: FETCH, HALTED.
- FETCH: each cycle imem_pc=pc. At the clock edge the pair {pc, imem_instruction} is enqueued if the queue is not full, or if it is full and a dequeue happens in the same cycle. On enqueue, pc<=pc+2 (16-bit wrap: 16'hFFFE -> 16'h0000) and fetch_count increments (saturating). With no enqueue, pc holds.
- If the enqueued instruction[15:11]==HALT_OPCODE: it is still enqueued, then go to HALTED with halted=1 and pc frozen at halt address+2. No further enqueues.
- HALTED: imem_pc holds. Decode still drains the queue. Only a redirect or reset leaves the state.
- Dequeue: occurs when if_valid && id_ready. The head advances at the edge.
- Latency: an instruction fetched in cycle N is visible on if_valid/if_instruction in cycle N+1 (registered queue head).
- Redirect priority: redirect_valid > dequeue > enqueue.
  - When redirect_valid=1 at an edge: flush the queue (if_valid=0 next cycle), discard any same-cycle enqueue and dequeue, set pc<=redirect_pc & 16'hFFFE, clear halted, go to FETCH.
  - The first redirected instruction reaches if_valid 2 cycles after the redirect edge.
- Back-to-back redirects: the last one wins.
- Queue full with id_ready=0: pc and imem_pc hold and contents stay stable. if_* outputs must not change while if_valid && !id_ready.
- Addresses >=256 return 16'd0 from memory; these are enqueued as ordinary instructions.
- fetch_count is not affected by flushes.

Decomposition:
- Shared package fetch_pkg:
  - PC_WIDTH=16, INSTR_WIDTH=16, PC_STEP=2, DEFAULT_RESET_PC, DEFAULT_HALT_OPCODE.
  - Entry struct/width {pc[15:0], instr[15:0]} = 32 bits.
- Sub-module fetch_queue: synchronous FIFO with parameterised depth.
  - Ports: enq, deq, flush, full, empty, head data.
  - Flush has priority over enq and deq. Pointers wrap modulo QUEUE_DEPTH.
- The top-level block holds the pc register, the FETCH/HALTED state machine and the counter.

Test Plan:
- Reset release, ROM words 16'hEB28, 16'h0808, then halt fill, id_ready=1 -> imem_pc 0,2,4; if_pc/if_instruction 0/16'hEB28 in cycle 2, 2/16'h0808 in cycle 3; fetch_count=3 after 3 enqueues.
- id_ready=0 for 5 cycles from reset -> exactly 2 enqueues; imem_pc stuck at 4; if_pc=0 stable. id_ready=1 -> if_pc 0,2,4 on consecutive cycles with no bubble.
- Halt word 16'hF800 at address 22 -> halted=1 after enqueueing it; imem_pc frozen at 24; queue drains; fetch_count stops increasing.
- redirect_valid with redirect_pc=16'h0011 while queue is full -> if_valid=0 next cycle; imem_pc=16'h0010; if_pc=16'h0010 valid 2 cycles after the redirect.
- Redirect during HALTED to 16'h0000 -> halted=0; fetching resumes from 0.
- Async reset pulse mid-stream (between edges) -> if_valid=0 and halted=0 immediately; imem_pc=RESET_PC. Redirect to 16'hFFFE -> next fetch pc wraps to 16'h0000.
